// File: rtl/banked_mem_controller.sv
// rtl/banked_mem_controller.sv - banked word-array controller with read/write request FIFOs
// Optional feature macro: MEM_CTRL_RAW_BYPASS_EN (read-after-write forwarding from the write queue)
module banked_mem_controller #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int NUM_BANKS   = 4,
  parameter int BANK_BUSY   = 3,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] wr_ret_address,
  output logic              wr_ret_ack,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_ret_data,
  output logic [ADDR_W-1:0] rd_ret_address,
  output logic              rd_ret_ack
);

  localparam int PTR_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int TMR_W  = (BANK_BUSY > 1) ? $clog2(BANK_BUSY) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(QUEUE_DEPTH);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(BANK_BUSY - 1);
  localparam logic [BANK_W-1:0] BANK_MASK = BANK_W'(NUM_BANKS - 1);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] wq_addr [QUEUE_DEPTH];
  logic [DATA_W-1:0] wq_data [QUEUE_DEPTH];
  logic [PTR_W-1:0]  wq_rptr, wq_wptr;
  logic [CNT_W-1:0]  wq_cnt;

  logic [ADDR_W-1:0] rq_addr [QUEUE_DEPTH];
  logic [PTR_W-1:0]  rq_rptr, rq_wptr;
  logic [CNT_W-1:0]  rq_cnt;

  logic [TMR_W-1:0]  bank_tmr [NUM_BANKS];

  logic              rd_s1_valid;
  logic [ADDR_W-1:0] rd_s1_addr;
  logic [DATA_W-1:0] rd_s1_data;

  logic              wr_push, rd_push;
  logic [ADDR_W-1:0] w_head_addr, r_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [BANK_W-1:0] w_bank, r_bank, issue_bank;
  logic              w_full, w_elig, r_elig, r_bypass;
  logic              r_match_q, r_match_in;
  logic [DATA_W-1:0] byp_data;
  logic              issue_w, issue_r, issue_bank_en;

  assign wr_ready = rst_n && (wq_cnt < DEPTH_C);
  assign rd_ready = rst_n && (rq_cnt < DEPTH_C);
  assign wr_push  = wr_en && wr_ready;
  assign rd_push  = rd_en && rd_ready;

  assign w_head_addr = wq_addr[wq_rptr];
  assign w_head_data = wq_data[wq_rptr];
  assign r_head_addr = rq_addr[rq_rptr];
  assign w_bank      = w_head_addr[BANK_W-1:0] & BANK_MASK;
  assign r_bank      = r_head_addr[BANK_W-1:0] & BANK_MASK;
  assign w_full      = (wq_cnt == DEPTH_C);

  // Scan queued writes oldest to youngest; the last hit is the youngest matching write
  always_comb begin
    r_match_q = 1'b0;
    byp_data  = '0;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      if ((CNT_W'(k) < wq_cnt) && (wq_addr[wq_rptr + PTR_W'(k)] == r_head_addr)) begin
        r_match_q = 1'b1;
        byp_data  = wq_data[wq_rptr + PTR_W'(k)];
      end
    end
  end

  // A write entering the queue on this edge must also be seen by a read issuing now
  assign r_match_in = wr_push && (wr_address == r_head_addr);

  // Eligibility and fixed-priority arbitration: one issue per cycle at most
  always_comb begin
    w_elig = (wq_cnt != '0) && (bank_tmr[w_bank] == '0);
`ifdef MEM_CTRL_RAW_BYPASS_EN
    r_bypass = r_match_q;
    r_elig   = (rq_cnt != '0) && !r_match_in && (r_match_q || (bank_tmr[r_bank] == '0));
`else
    r_bypass = 1'b0;
    r_elig   = (rq_cnt != '0) && !r_match_in && !r_match_q && (bank_tmr[r_bank] == '0);
`endif
    issue_w       = w_elig && (w_full || !r_elig);
    issue_r       = r_elig && !(w_full && w_elig);
    issue_bank_en = issue_w || (issue_r && !r_bypass);
    issue_bank    = issue_w ? w_bank : r_bank;
  end

  // Queue pointers and occupancy counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wq_rptr <= '0;
      wq_wptr <= '0;
      wq_cnt  <= '0;
      rq_rptr <= '0;
      rq_wptr <= '0;
      rq_cnt  <= '0;
    end else begin
      if (wr_push) wq_wptr <= wq_wptr + 1'b1;
      if (issue_w) wq_rptr <= wq_rptr + 1'b1;
      wq_cnt <= wq_cnt + CNT_W'(wr_push) - CNT_W'(issue_w);
      if (rd_push) rq_wptr <= rq_wptr + 1'b1;
      if (issue_r) rq_rptr <= rq_rptr + 1'b1;
      rq_cnt <= rq_cnt + CNT_W'(rd_push) - CNT_W'(issue_r);
    end
  end

  // Queue storage, word array and read data capture (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_push) begin
      wq_addr[wq_wptr] <= wr_address;
      wq_data[wq_wptr] <= wr_data;
    end
    if (rd_push) rq_addr[rq_wptr] <= rd_address;
    if (issue_w) mem[w_head_addr] <= w_head_data;
    if (issue_r) begin
      rd_s1_addr <= r_head_addr;
      rd_s1_data <= r_bypass ? byp_data : mem[r_head_addr];
    end
  end

  // Bank busy timers: load on issue, count down to free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) bank_tmr[b] <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (issue_bank_en && (issue_bank == BANK_W'(b))) bank_tmr[b] <= TMR_LOAD;
        else if (bank_tmr[b] != '0)                      bank_tmr[b] <= bank_tmr[b] - 1'b1;
      end
    end
  end

  // Return pipeline: write ack one edge after issue, read ack two edges after issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_s1_valid    <= 1'b0;
      wr_ret_ack     <= 1'b0;
      wr_ret_address <= '0;
      rd_ret_ack     <= 1'b0;
      rd_ret_address <= '0;
      rd_ret_data    <= '0;
    end else begin
      rd_s1_valid <= issue_r;
      wr_ret_ack  <= issue_w;
      if (issue_w) wr_ret_address <= w_head_addr;
      rd_ret_ack  <= rd_s1_valid;
      if (rd_s1_valid) begin
        rd_ret_address <= rd_s1_addr;
        rd_ret_data    <= rd_s1_data;
      end
    end
  end

endmodule

// File: tb/tb_banked_mem_controller.sv
// tb/tb_banked_mem_controller.sv - directed self-checking bench for banked_mem_controller
module tb_banked_mem_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_address = '0;
  logic [15:0] wr_data = '0;
  logic        wr_ready;
  logic [15:0] wr_ret_address;
  logic        wr_ret_ack;
  logic        rd_en = 1'b0;
  logic [15:0] rd_address = '0;
  logic        rd_ready;
  logic [15:0] rd_ret_data;
  logic [15:0] rd_ret_address;
  logic        rd_ret_ack;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int base;
  int rd_cyc_q[$];
  int wr_cyc_q[$];
  logic [15:0] rd_addr_q[$];
  logic [15:0] rd_data_q[$];
  logic [15:0] wr_addr_q[$];

  banked_mem_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .wr_ready       (wr_ready),
    .wr_ret_address (wr_ret_address),
    .wr_ret_ack     (wr_ret_ack),
    .rd_en          (rd_en),
    .rd_address     (rd_address),
    .rd_ready       (rd_ready),
    .rd_ret_data    (rd_ret_data),
    .rd_ret_address (rd_ret_address),
    .rd_ret_ack     (rd_ret_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, sample just after it and log any acks with their cycle number
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rd_ret_ack) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(rd_ret_address);
      rd_data_q.push_back(rd_ret_data);
    end
    if (wr_ret_ack) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_q.push_back(wr_ret_address);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    rd_cyc_q = {};
    wr_cyc_q = {};
    rd_addr_q = {};
    rd_data_q = {};
    wr_addr_q = {};
  endtask

  function automatic int qi(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic logic [31:0] ql(input logic [15:0] q[$], input int i);
    return (q.size() > i) ? {16'h0, q[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    // Reset held with requests presented
    wr_en = 1'b1; wr_address = 16'h0010; wr_data = 16'h0055;
    rd_en = 1'b1; rd_address = 16'h0010;
    idle(3);
    check_eq("rst_wr_ready", wr_ready, 0);
    check_eq("rst_rd_ready", rd_ready, 0);
    check_eq("rst_outputs", {wr_ret_ack, rd_ret_ack, wr_ret_address, rd_ret_address}, 0);
    check_eq("rst_rd_data", rd_ret_data, 0);
    check_eq("rst_ack_count", wr_cyc_q.size() + rd_cyc_q.size(), 0);
    wr_en = 1'b0; rd_en = 1'b0;
    rst_n = 1'b1;
    tick();
    check_eq("rel_ready", {wr_ready, rd_ready}, 2'b11);

    // Basic write then read
    wr_en = 1'b1; wr_address = 16'h0010; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    check_eq("wr_ack_early", wr_ret_ack, 0);
    tick();
    check_eq("wr_ack", wr_ret_ack, 1);
    check_eq("wr_ack_tag", wr_ret_address, 16'h0010);
    tick();
    check_eq("wr_ack_pulse", wr_ret_ack, 0);
    rd_en = 1'b1; rd_address = 16'h0010;
    tick();
    rd_en = 1'b0;
    tick();
    check_eq("rd_ack_early", rd_ret_ack, 0);
    tick();
    check_eq("rd_ack", rd_ret_ack, 1);
    check_eq("rd_data", rd_ret_data, 16'hBEEF);
    check_eq("rd_tag", rd_ret_address, 16'h0010);
    tick();
    check_eq("rd_ack_pulse", rd_ret_ack, 0);
    check_eq("rd_data_hold", rd_ret_data, 16'hBEEF);

    // Same-bank reads are spaced by the bank busy time
    idle(5);
    clear_log();
    rd_en = 1'b1; rd_address = 16'h0004;
    tick();
    base = cyc;
    rd_address = 16'h0008;
    tick();
    rd_en = 1'b0;
    idle(10);
    check_eq("bank_same_cnt", rd_cyc_q.size(), 2);
    check_eq("bank_same_first", qi(rd_cyc_q, 0), base + 2);
    check_eq("bank_same_gap", qi(rd_cyc_q, 1) - qi(rd_cyc_q, 0), 3);

    // Different-bank reads return back to back
    clear_log();
    rd_en = 1'b1; rd_address = 16'h0004;
    tick();
    rd_address = 16'h0005;
    tick();
    rd_en = 1'b0;
    idle(8);
    check_eq("bank_diff_cnt", rd_cyc_q.size(), 2);
    check_eq("bank_diff_gap", qi(rd_cyc_q, 1) - qi(rd_cyc_q, 0), 1);
    check_eq("bank_diff_tag", ql(rd_addr_q, 1), 16'h0005);

    // Write queue fills behind a busy bank; a full queue drains ahead of a pending read
    clear_log();
    wr_en = 1'b1; wr_address = 16'h0100; wr_data = 16'hA000;
    tick();
    wr_address = 16'h0104; wr_data = 16'hA001;
    tick();
    check_eq("bp_ack0_tag", wr_ret_address, 16'h0100);
    wr_address = 16'h0108; wr_data = 16'hA002;
    tick();
    wr_address = 16'h010C; wr_data = 16'hA003;
    tick();
    wr_address = 16'h0110; wr_data = 16'hA004;
    tick();
    check_eq("bp_ack1_tag", wr_ret_address, 16'h0104);
    wr_address = 16'h0114; wr_data = 16'hA005;
    rd_en = 1'b1; rd_address = 16'h0200;
    tick();
    check_eq("bp_full", wr_ready, 0);
    rd_en = 1'b0;
    wr_address = 16'h0118; wr_data = 16'hA006;
    tick();
    check_eq("bp_held", wr_ready, 0);
    tick();
    base = cyc;
    wr_en = 1'b0;
    check_eq("bp_drain_ack", wr_ret_ack, 1);
    check_eq("bp_drain_tag", wr_ret_address, 16'h0108);
    check_eq("bp_ready_again", wr_ready, 1);
    idle(15);
    check_eq("bp_rd_cyc", qi(rd_cyc_q, 0), base + 4);
    check_eq("bp_rd_tag", ql(rd_addr_q, 0), 16'h0200);
    check_eq("bp_wr_total", wr_cyc_q.size(), 6);
    check_eq("bp_w3_cyc", qi(wr_cyc_q, 3), base + 6);

    // Read after write to the same address, accepted on the same edge, bank made busy first
    clear_log();
    wr_en = 1'b1; wr_address = 16'h0024; wr_data = 16'h5555;
    tick();
    wr_address = 16'h0020; wr_data = 16'h1234;
    rd_en = 1'b1; rd_address = 16'h0020;
    tick();
    base = cyc;
    wr_en = 1'b0; rd_en = 1'b0;
    idle(10);
    check_eq("raw_rd_cnt", rd_cyc_q.size(), 1);
    check_eq("raw_rd_data", ql(rd_data_q, 0), 16'h1234);
    check_eq("raw_wr_tag", ql(wr_addr_q, 1), 16'h0020);
    check_eq("raw_wr_cyc", qi(wr_cyc_q, 1), base + 3);
`ifdef MEM_CTRL_RAW_BYPASS_EN
    check_eq("raw_rd_cyc", qi(rd_cyc_q, 0), base + 2);
`else
    check_eq("raw_rd_cyc", qi(rd_cyc_q, 0), base + 7);
`endif

    // Reset in the middle of queued reads drops them
    idle(4);
    rd_en = 1'b1; rd_address = 16'h0040;
    tick();
    rd_address = 16'h0044;
    tick();
    rd_address = 16'h0048;
    tick();
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", {wr_ready, rd_ready}, 2'b00);
    check_eq("mid_rst_ack", {wr_ret_ack, rd_ret_ack}, 2'b00);
    clear_log();
    idle(2);
    rst_n = 1'b1;
    tick();
    check_eq("mid_rel_ready", rd_ready, 1);
    idle(10);
    check_eq("mid_no_acks", rd_cyc_q.size() + wr_cyc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
